// File: rtl/ibex_rf_ctx_swap.sv
// rtl/ibex_rf_ctx_swap.sv - register-file context spill/fill engine on the data bus
module ibex_rf_ctx_swap #(
  parameter int unsigned NumCtx      = 4,
  parameter int unsigned NumRegs     = 32,
  parameter logic [31:0] CtxBaseAddr = 32'h0010_0000,
  parameter int unsigned CtxStride   = NumRegs * 4,
  localparam int unsigned CtxW       = $clog2(NumCtx)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [31:0]     ctx_sel_i,
  output logic            busy_o,
  output logic [CtxW-1:0] cur_ctx_o,
  output logic            err_o,
  input  logic            data_req_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  input  logic            data_we_i,
  input  logic [3:0]      data_be_i,
  input  logic [31:0]     data_addr_i,
  input  logic [31:0]     data_wdata_i,
  output logic [31:0]     data_rdata_o,
  output logic            data_err_o,
  output logic            data_req_o,
  input  logic            data_gnt_i,
  input  logic            data_rvalid_i,
  output logic            data_we_o,
  output logic [3:0]      data_be_o,
  output logic [31:0]     data_addr_o,
  output logic [31:0]     data_wdata_o,
  input  logic [31:0]     data_rdata_i,
  input  logic            data_err_i,
  output logic [4:0]      rf_raddr_o,
  input  logic [31:0]     rf_rdata_i,
  output logic [4:0]      rf_waddr_o,
  output logic [31:0]     rf_wdata_o,
  output logic            rf_we_o
);

  typedef enum logic [2:0] {
    IDLE, DRAIN, SPILL_REQ, SPILL_WAIT, FILL_REQ, FILL_WAIT, DONE
  } state_e;

  state_e          state_q;
  logic [4:0]      idx_q;
  logic [CtxW-1:0] cur_ctx_q, new_ctx_q;
  logic            busy_q, err_q, outstanding_q;

  logic [CtxW-1:0] sel_ctx;
  logic [CtxW-1:0] slot_ctx;
  logic            swap_start, drain_needed, last_reg, swap_rsp;
  logic [31:0]     slot_addr;

  assign sel_ctx    = ctx_sel_i[CtxW-1:0];
  assign swap_start = (sel_ctx != cur_ctx_q) && (ctx_sel_i < 32'(NumCtx));
  // A response arriving in the trigger cycle retires the pending access itself.
  assign drain_needed = (data_req_i && data_gnt_i) || (outstanding_q && !data_rvalid_i);
  assign last_reg   = (idx_q == 5'(NumRegs - 1));
  assign swap_rsp   = data_rvalid_i && ((state_q == SPILL_WAIT) || (state_q == FILL_WAIT));
  assign slot_ctx   = (state_q == FILL_REQ) ? new_ctx_q : cur_ctx_q;
  assign slot_addr  = CtxBaseAddr + 32'(slot_ctx) * 32'(CtxStride) + {25'd0, idx_q, 2'b00};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      idx_q         <= 5'd1;
      cur_ctx_q     <= '0;
      new_ctx_q     <= '0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_req_i && data_gnt_i) outstanding_q <= 1'b1;
          else if (data_rvalid_i)       outstanding_q <= 1'b0;
          if (swap_start) begin
            new_ctx_q <= sel_ctx;
            busy_q    <= 1'b1;
            state_q   <= drain_needed ? DRAIN : SPILL_REQ;
          end
        end
        DRAIN: if (data_rvalid_i) begin
          outstanding_q <= 1'b0;
          state_q       <= SPILL_REQ;
        end
        SPILL_REQ: if (data_gnt_i) state_q <= SPILL_WAIT;
        SPILL_WAIT: if (data_rvalid_i) begin
          idx_q   <= last_reg ? 5'd1 : idx_q + 5'd1;
          state_q <= last_reg ? FILL_REQ : SPILL_REQ;
        end
        FILL_REQ: if (data_gnt_i) state_q <= FILL_WAIT;
        FILL_WAIT: if (data_rvalid_i) begin
          idx_q   <= last_reg ? 5'd1 : idx_q + 5'd1;
          state_q <= last_reg ? DONE : FILL_REQ;
        end
        DONE: begin
          cur_ctx_q <= new_ctx_q;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (swap_rsp && data_err_i) err_q <= 1'b1;
    end
  end

  always_comb begin
    data_req_o    = 1'b0;
    data_we_o     = 1'b0;
    data_be_o     = 4'h0;
    data_addr_o   = 32'h0;
    data_wdata_o  = 32'h0;
    data_gnt_o    = 1'b0;
    data_rvalid_o = 1'b0;
    data_err_o    = 1'b0;
    case (state_q)
      IDLE: begin
        data_req_o    = data_req_i;
        data_we_o     = data_we_i;
        data_be_o     = data_be_i;
        data_addr_o   = data_addr_i;
        data_wdata_o  = data_wdata_i;
        data_gnt_o    = data_gnt_i;
        data_rvalid_o = data_rvalid_i;
        data_err_o    = data_err_i;
      end
      DRAIN: begin
        data_rvalid_o = data_rvalid_i;
        data_err_o    = data_err_i;
      end
      SPILL_REQ: begin
        data_req_o   = 1'b1;
        data_we_o    = 1'b1;
        data_be_o    = 4'hF;
        data_addr_o  = slot_addr;
        data_wdata_o = rf_rdata_i;
      end
      FILL_REQ: begin
        data_req_o  = 1'b1;
        data_be_o   = 4'hF;
        data_addr_o = slot_addr;
      end
      default: ;
    endcase
  end

  assign data_rdata_o = data_rdata_i;
  assign rf_raddr_o   = idx_q;
  assign rf_waddr_o   = idx_q;
  assign rf_wdata_o   = data_rdata_i;
  assign rf_we_o      = (state_q == FILL_WAIT) && data_rvalid_i;
  assign busy_o       = busy_q;
  assign cur_ctx_o    = cur_ctx_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ibex_rf_ctx_swap.sv
// tb/tb_ibex_rf_ctx_swap.sv - scoreboard bench for the register-file context swapper
module tb_ibex_rf_ctx_swap;
  localparam int NR = 32;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ctx_sel_i;
  logic        busy_o, err_o;
  logic [1:0]  cur_ctx_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o, data_err_i;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [4:0]  rf_raddr_o, rf_waddr_o;
  logic [31:0] rf_rdata_i, rf_wdata_o;
  logic        rf_we_o;

  ibex_rf_ctx_swap dut (
    .clk_i(clk), .rst_ni(rst_ni), .ctx_sel_i(ctx_sel_i), .busy_o(busy_o),
    .cur_ctx_o(cur_ctx_o), .err_o(err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_addr_o(data_addr_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o)
  );

  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata;} bus_t;
  typedef struct {logic [4:0] idx; logic [31:0] data;} rfw_t;
  typedef struct {logic is_load; logic [31:0] data;} core_t;
  typedef struct {int due; logic [31:0] data; logic swap;} rsp_t;

  bus_t  bus_q[$];
  rfw_t  rf_q[$];
  core_t core_q[$];
  rsp_t  rsp_q[$];

  logic [31:0] rf [32];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] core_mem [logic [31:0]];
  logic [31:0] live [32];
  logic [31:0] slot [4][32];

  int n_chk = 0, n_err = 0;
  int lat = 1, err_at = 0, swap_rsp_cnt = 0, cyc = 0;
  int busy_cnt = 0, rf_we_cnt = 0;
  bit core_load_pending = 0;

  assign rf_rdata_i = rf[rf_raddr_o];
  assign data_gnt_i = data_req_o;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] slot_addr(input int c, input int r);
    return BASE + 32'(c) * 32'(NR * 4) + 32'(4 * r);
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a swap saves the live registers into slot a and loads slot b.
  task automatic expect_swap(input int a, input int b);
    for (int r = 1; r < NR; r++) begin
      bus_q.push_back('{slot_addr(a, r), 1'b1, live[r]});
      slot[a][r] = live[r];
    end
    for (int r = 1; r < NR; r++) begin
      bus_q.push_back('{slot_addr(b, r), 1'b0, 32'h0});
      rf_q.push_back('{5'(r), slot[b][r]});
      live[r] = slot[b][r];
    end
  endtask

  // Memory: grants immediately, answers after lat cycles.
  initial begin : memory
    rsp_t rs;
    logic [31:0] rd;
    data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
    forever begin
      @(negedge clk);
      cyc++;
      data_rvalid_i = 0; data_err_i = 0; data_rdata_i = 0;
      if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
        rs = rsp_q.pop_front();
        data_rvalid_i = 1; data_rdata_i = rs.data;
        if (rs.swap) begin
          swap_rsp_cnt++;
          data_err_i = (err_at != 0 && swap_rsp_cnt == err_at);
        end
      end
      if (rst_ni && data_req_o && data_gnt_i) begin
        rd = mem.exists(data_addr_o) ? mem[data_addr_o] : dflt(data_addr_o);
        if (data_we_o) begin
          mem[data_addr_o] = data_wdata_o;
          rd = 32'h0;
        end
        rsp_q.push_back('{cyc + lat, rd, busy_o});
      end
    end
  end

  initial begin : monitor
    bus_t e;
    rfw_t w;
    core_t c;
    forever begin
      @(negedge clk); #2;
      if (rst_ni) begin
        if (busy_o) begin
          busy_cnt++;
          chk(data_gnt_o == 1'b0, "gnt_blocked", 32'(data_gnt_o), 32'h0);
        end
        if (busy_o && data_req_o && data_gnt_i) begin
          chk(!core_load_pending, "req_before_drain", 32'(core_load_pending), 32'h0);
          if (bus_q.size() == 0) chk(0, "bus_extra", data_addr_o, 32'h0);
          else begin
            e = bus_q.pop_front();
            chk(data_addr_o === e.addr, "swap_addr", data_addr_o, e.addr);
            chk(data_we_o === e.we, "swap_we", 32'(data_we_o), 32'(e.we));
            chk(data_be_o === 4'hF, "swap_be", 32'(data_be_o), 32'hF);
            if (e.we) chk(data_wdata_o === e.wdata, "spill_data", data_wdata_o, e.wdata);
          end
        end
        if (rf_we_o) begin
          rf_we_cnt++;
          rf[rf_waddr_o] = rf_wdata_o;
          if (rf_q.size() == 0) chk(0, "rf_extra", 32'(rf_waddr_o), 32'h0);
          else begin
            w = rf_q.pop_front();
            chk(rf_waddr_o === w.idx, "fill_idx", 32'(rf_waddr_o), 32'(w.idx));
            chk(rf_wdata_o === w.data, "fill_data", rf_wdata_o, w.data);
          end
        end
        if (data_rvalid_o) begin
          core_load_pending = 0;
          if (core_q.size() == 0) chk(0, "core_extra_rvalid", data_rdata_o, 32'h0);
          else begin
            c = core_q.pop_front();
            if (c.is_load) begin
              chk(data_rdata_o === c.data, "core_rdata", data_rdata_o, c.data);
              chk(data_err_o === 1'b0, "core_err", 32'(data_err_o), 32'h0);
            end
          end
        end
      end
    end
  end

  task automatic core_acc(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit wait_rsp);
    bit granted = 0;
    @(posedge clk); #1;
    data_req_i = 1; data_we_i = we; data_addr_i = addr; data_wdata_i = wd; data_be_i = 4'hF;
    for (int i = 0; i < 50 && !granted; i++) begin
      @(negedge clk); #3;
      if (data_gnt_o) granted = 1;
    end
    chk(granted, "core_gnt", 32'(granted), 32'h1);
    if (granted) begin
      if (we) begin
        core_q.push_back('{1'b0, 32'h0});
        core_mem[addr] = wd;
      end else begin
        core_q.push_back('{1'b1, core_mem.exists(addr) ? core_mem[addr] : dflt(addr)});
        core_load_pending = 1;
      end
    end
    @(posedge clk); #1;
    data_req_i = 0;
    if (wait_rsp) begin
      for (int i = 0; i < 50 && core_q.size() != 0; i++) @(negedge clk);
      chk(core_q.size() == 0, "core_rsp_timeout", 32'(core_q.size()), 32'h0);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk); #3;
      if (!busy_o) ok = 1;
    end
    chk(ok, "swap_timeout", 32'(busy_o), 32'h0);
  endtask

  task automatic start_swap(input int a, input int b);
    @(posedge clk); #1;
    busy_cnt = 0;
    ctx_sel_i = 32'(b);
    expect_swap(a, b);
    @(negedge clk); #3;
  endtask

  task automatic check_swap_done(input int b, input bit zero_wait, input int fills_before);
    chk(cur_ctx_o === 2'(b), "cur_ctx", 32'(cur_ctx_o), 32'(b));
    chk(bus_q.size() == 0 && rf_q.size() == 0, "swap_incomplete", 32'(bus_q.size() + rf_q.size()), 32'h0);
    chk(rf_we_cnt - fills_before == NR - 1, "fill_count", 32'(rf_we_cnt - fills_before), 32'(NR - 1));
    if (zero_wait) chk(busy_cnt == 4 * (NR - 1) + 1, "busy_cycles", 32'(busy_cnt), 32'(4 * (NR - 1) + 1));
  endtask

  initial begin : stim
    int mism, act, f0;
    logic [31:0] a, d;
    ctx_sel_i = 0; data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    rf[0] = 0; live[0] = 0;
    for (int r = 1; r < NR; r++) begin
      rf[r] = $urandom; live[r] = rf[r];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < NR; r++) slot[c][r] = dflt(slot_addr(c, r));

    repeat (3) @(posedge clk); #1;
    chk(busy_o === 1'b0, "rst_busy", 32'(busy_o), 32'h0);
    chk(cur_ctx_o === 2'd0, "rst_ctx", 32'(cur_ctx_o), 32'h0);
    chk(err_o === 1'b0, "rst_err", 32'(err_o), 32'h0);
    chk(rf_we_o === 1'b0, "rst_rf_we", 32'(rf_we_o), 32'h0);
    chk(data_req_o === 1'b0, "rst_req", 32'(data_req_o), 32'h0);
    rst_ni = 1;

    for (int i = 0; i < 6; i++) begin
      a = 32'h2000_0000 + 32'($urandom_range(0, 63) * 4);
      d = $urandom;
      core_acc(1, a, d, 1);
      core_acc(0, a, 32'h0, 1);
      core_acc(0, 32'h2000_1000 + 32'($urandom_range(0, 63) * 4), 32'h0, 1);
    end
    chk(busy_o === 1'b0 && cur_ctx_o === 2'd0, "passthru_idle", {30'd0, cur_ctx_o} | 32'(busy_o), 32'h0);

    f0 = rf_we_cnt;
    start_swap(0, 2);
    wait_idle();
    check_swap_done(2, 1, f0);
    mism = 0;
    for (int r = 1; r < NR; r++) if (rf[r] !== live[r]) mism++;
    chk(mism == 0, "rf_contents", 32'(mism), 32'h0);

    @(posedge clk); #1;
    busy_cnt = 0; ctx_sel_i = 32'd7;
    repeat (6) @(negedge clk); #3;
    chk(busy_cnt == 0 && busy_o === 1'b0, "sel_out_of_range", 32'(busy_cnt), 32'h0);
    chk(cur_ctx_o === 2'd2, "ctx_kept", 32'(cur_ctx_o), 32'h2);

    lat = 3;
    core_acc(0, 32'h2000_2000, 32'h0, 0);
    lat = 1;
    f0 = rf_we_cnt;
    busy_cnt = 0; ctx_sel_i = 32'd1;
    expect_swap(2, 1);
    @(negedge clk); #3;
    wait_idle();
    check_swap_done(1, 0, f0);
    chk(core_q.size() == 0, "drain_core_data", 32'(core_q.size()), 32'h0);

    chk(err_o === 1'b0, "err_clear", 32'(err_o), 32'h0);
    swap_rsp_cnt = 0; err_at = 5;
    f0 = rf_we_cnt;
    start_swap(1, 0);
    wait_idle();
    err_at = 0;
    check_swap_done(0, 1, f0);
    chk(err_o === 1'b1, "err_set", 32'(err_o), 32'h1);

    f0 = rf_we_cnt;
    start_swap(0, 1);
    repeat (20) @(posedge clk);
    #1 ctx_sel_i = 32'd3;
    wait_idle();
    check_swap_done(1, 0, f0);
    f0 = rf_we_cnt;
    expect_swap(1, 3);
    @(negedge clk); #3;
    chk(busy_o === 1'b1, "second_swap_start", 32'(busy_o), 32'h1);
    wait_idle();
    check_swap_done(3, 0, f0);
    chk(err_o === 1'b1, "err_sticky", 32'(err_o), 32'h1);

    f0 = rf_we_cnt;
    start_swap(3, 2);
    for (int i = 0; i < 3000 && rf_we_cnt < f0 + 5; i++) @(negedge clk);
    chk(rf_we_cnt >= f0 + 5, "fill_reach_timeout", 32'(rf_we_cnt - f0), 32'h5);
    @(posedge clk); #1;
    rst_ni = 0; ctx_sel_i = 0;
    rsp_q.delete(); bus_q.delete(); rf_q.delete();
    #1;
    chk(busy_o === 1'b0, "midrst_busy", 32'(busy_o), 32'h0);
    chk(cur_ctx_o === 2'd0, "midrst_ctx", 32'(cur_ctx_o), 32'h0);
    chk(rf_we_o === 1'b0, "midrst_rf_we", 32'(rf_we_o), 32'h0);
    chk(data_req_o === 1'b0, "midrst_req", 32'(data_req_o), 32'h0);
    chk(err_o === 1'b0, "midrst_err", 32'(err_o), 32'h0);
    repeat (2) @(posedge clk); #1;
    rst_ni = 1;
    act = 0;
    repeat (10) begin
      @(negedge clk); #3;
      if (data_req_o || busy_o || rf_we_o) act++;
    end
    chk(act == 0, "post_rst_quiet", 32'(act), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
